// File: rtl/vga_reg_bar_display.sv
// rtl/vga_reg_bar_display.sv - VGA timing generator with per-register bar display
//
// Generates VGA sync/colour from a CLK-divided pixel tick. Once per frame, at the
// start of vertical blanking, NUM_REGS bytes are fetched from the register memory
// into a shadow buffer. Each register is drawn as one horizontal bar whose length
// is value*BAR_SCALE pixels, in its own band of BAND_H lines.
// Optional macro: VGA_BORDER_EN draws a white one-pixel frame around the active area.
//
// Ports:
//   CLK         system clock, all logic on posedge
//   RESET       synchronous reset, active-low
//   MemAddrOut  register memory address (ADDR_W bits)
//   MemRd       high while MemAddrOut carries a fetch request
//   MemDataIN   register memory read data, valid READ_LAT cycles after the address
//   HSync/VSync sync outputs, active-low
//   R, G, B     4-bit colour, 0 outside the active area
//   PosX/PosY   coordinates of the pixel currently on R/G/B
//   FrameStart  one-CLK pulse when pixel (0,0) is presented
module vga_reg_bar_display #(
  parameter int          CLK_DIV   = 4,
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter int          NUM_REGS  = 16,
  parameter int          BAND_H    = 30,
  parameter int          BAR_SCALE = 2,
  parameter logic [11:0] FG_RGB    = 12'hFFF,
  parameter int          READ_LAT  = 1,
  parameter int          ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [ADDR_W-1:0] MemAddrOut,
  output logic              MemRd,
  input  logic [7:0]        MemDataIN,
  output logic              HSync,
  output logic              VSync,
  output logic [3:0]        R,
  output logic [3:0]        G,
  output logic [3:0]        B,
  output logic [9:0]        PosX,
  output logic [9:0]        PosY,
  output logic              FrameStart
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [DW-1:0]     DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [9:0]        H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]        V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]        HS_BEG    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]        HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]        VS_BEG    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]        VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]        H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]        V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0]        BAND_H_W  = 10'(BAND_H);
  localparam logic [9:0]        NREGS_W   = 10'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [LW-1:0]     DRAIN_END = LW'(READ_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} fetch_state_t;

  logic [DW-1:0] div;
  logic          tick;
  logic [9:0]    hcnt, vcnt;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (tick) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Shadow buffer: only the fetch writes it, and the fetch runs in vertical
  // blanking, so a frame always shows one consistent snapshot.
  logic [7:0] shadow [NUM_REGS];

  logic [9:0]  band;
  logic        active;
  logic [17:0] bar_len;
  logic        lit;
  logic [11:0] rgb_n;

  always_comb begin
    band    = vcnt / BAND_H_W;
    active  = (hcnt < H_ACT) && (vcnt < V_ACT);
    bar_len = '0;
    if (band < NREGS_W) begin
      bar_len = 18'(shadow[band[ADDR_W-1:0]]) * 18'(BAR_SCALE);
    end
    // hcnt < H_ACTIVE inside the active area, so long bars clip at the right edge.
    lit   = active && (band < NREGS_W) && (18'(hcnt) < bar_len);
    rgb_n = lit ? FG_RGB : 12'h000;
`ifdef VGA_BORDER_EN
    if (active && (hcnt == 10'd0 || hcnt == H_ACT - 10'd1 ||
                   vcnt == 10'd0 || vcnt == V_ACT - 10'd1)) begin
      rgb_n = 12'hFFF;
    end
`endif
  end

  // All video outputs register together on the tick, one tick behind hcnt/vcnt.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      HSync     <= 1'b1;
      VSync     <= 1'b1;
      {R, G, B} <= 12'h000;
      PosX      <= '0;
      PosY      <= '0;
    end else if (tick) begin
      HSync     <= !((hcnt >= HS_BEG) && (hcnt < HS_END));
      VSync     <= !((vcnt >= VS_BEG) && (vcnt < VS_END));
      {R, G, B} <= rgb_n;
      PosX      <= hcnt;
      PosY      <= vcnt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      FrameStart <= 1'b0;
    end else begin
      FrameStart <= tick && (hcnt == 10'd0) && (vcnt == 10'd0);
    end
  end

  // Fetch FSM: starts on the tick that presents the first blanking line.
  fetch_state_t       state, state_n;
  logic [ADDR_W-1:0]  idx, idx_n;
  logic [LW-1:0]      drain_cnt, drain_n;
  logic               start_fetch;

  assign start_fetch = tick && (hcnt == 10'd0) && (vcnt == V_ACT);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= S_IDLE;
      idx       <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      drain_cnt <= drain_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    drain_n    = drain_cnt;
    MemRd      = 1'b0;
    MemAddrOut = idx;
    case (state)
      S_IDLE: begin
        if (start_fetch) begin
          state_n = S_REQ;
          idx_n   = '0;
        end
      end
      S_REQ: begin
        MemRd = 1'b1;
        if (idx == LAST_ADDR) begin
          state_n = S_DRAIN;
          idx_n   = '0;
          drain_n = '0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_END) begin
          state_n = S_IDLE;
        end else begin
          drain_n = drain_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Request pipeline delays each address by READ_LAT to line up with MemDataIN.
  logic              pipe_v [READ_LAT];
  logic [ADDR_W-1:0] pipe_a [READ_LAT];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int k = 0; k < READ_LAT; k++) begin
        pipe_v[k] <= 1'b0;
        pipe_a[k] <= '0;
      end
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      pipe_v[0] <= MemRd;
      pipe_a[0] <= MemAddrOut;
      for (int k = 1; k < READ_LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_a[k] <= pipe_a[k-1];
      end
      if (pipe_v[READ_LAT-1]) begin
        shadow[pipe_a[READ_LAT-1]] <= MemDataIN;
      end
    end
  end

endmodule

// File: tb/tb_vga_reg_bar_display.sv
// tb/tb_vga_reg_bar_display.sv - directed bench for vga_reg_bar_display on a reduced raster
module tb_vga_reg_bar_display;

  // Reduced raster: line = 28 px * 2 CLK = 56 CLK, frame = 22 lines = 1232 CLK.
  localparam int CLK_DIV = 2;
  localparam int LINE_CLK = 56;
  localparam int FRAME_CLK = 1232;
  localparam logic [11:0] FG = 12'hFFF;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] MemAddrOut;
  logic       MemRd;
  logic [7:0] MemDataIN;
  logic       HSync, VSync;
  logic [3:0] R, G, B;
  logic [9:0] PosX, PosY;
  logic       FrameStart;

  vga_reg_bar_display #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .NUM_REGS(4), .BAND_H(4), .BAR_SCALE(2), .FG_RGB(FG), .READ_LAT(1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .MemAddrOut(MemAddrOut), .MemRd(MemRd),
    .MemDataIN(MemDataIN), .HSync(HSync), .VSync(VSync), .R(R), .G(G), .B(B),
    .PosX(PosX), .PosY(PosY), .FrameStart(FrameStart)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  logic [7:0] mem [4];
  always @(posedge CLK) MemDataIN <= mem[MemAddrOut];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_pos(input int x, input int y);
    for (int i = 0; i < 3000; i++) begin
      if (PosX == 10'(x) && PosY == 10'(y)) break;
      @(negedge CLK);
    end
    chk($sformatf("reach_%0d_%0d", x, y), 32'(PosX == 10'(x) && PosY == 10'(y)), 32'd1);
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
    wait_pos(x, y);
    chk(tag, 32'({R, G, B}), 32'(exp));
  endtask

  initial begin
    int t0;
    int n;
    RESET = 1'b0;
    mem[0] = 8'd3; mem[1] = 8'd5; mem[2] = 8'd8; mem[3] = 8'd12;

    // T1: outputs held at reset values
    @(negedge CLK);
    for (int k = 0; k < 5; k++) begin
      chk("t1_sync_rgb", 32'({HSync, VSync, R, G, B}), 32'h3000);
      chk("t1_pos", 32'({PosX, PosY}), 32'd0);
      chk("t1_mem", 32'({MemRd, FrameStart, MemAddrOut}), 32'd0);
      @(negedge CLK);
    end
    RESET = 1'b1;

    // Frame 0: shadow is empty
    pix("f0_empty", 2, 1, 12'h000);

    // T2: HSync position, width and line period
    for (int i = 0; i < 200 && HSync !== 1'b0; i++) @(negedge CLK);
    chk("hs_fall_posx", 32'(PosX), 32'd22);
    t0 = cyc;
    n = 0;
    while (HSync === 1'b0 && n < 100) begin @(negedge CLK); n++; end
    chk("hs_low_clk", 32'(n), 32'd6);
    for (int i = 0; i < 200 && HSync !== 1'b0; i++) @(negedge CLK);
    chk("line_period", 32'(cyc - t0), 32'(LINE_CLK));

    // T4: fetch sequence at the first blanking line
    for (int i = 0; i < 2000 && MemRd !== 1'b1; i++) @(negedge CLK);
    chk("fetch_posy", 32'(PosY), 32'd16);
    for (int a = 0; a < 4; a++) begin
      chk("fetch_rd", 32'(MemRd), 32'd1);
      chk("fetch_addr", 32'(MemAddrOut), 32'(a));
      @(negedge CLK);
    end
    chk("fetch_end", 32'(MemRd), 32'd0);

    // T3: VSync position and width
    for (int i = 0; i < 2000 && VSync !== 1'b0; i++) @(negedge CLK);
    chk("vs_fall_pos", 32'({PosX, PosY}), 32'd18);
    n = 0;
    while (VSync === 1'b0 && n < 1000) begin @(negedge CLK); n++; end
    chk("vs_low_clk", 32'(n), 32'(2 * LINE_CLK));

    // Frame 1: bars 6, 10, 16 and 24 (clipped to 20) px
    pix("f1_b0_in", 5, 1, FG);
    pix("f1_b0_out", 6, 1, 12'h000);
    pix("f1_b1_in", 9, 5, FG);
    pix("f1_b1_out", 10, 5, 12'h000);
    wait_pos(0, 8);
    mem[2] = 8'd2;
    pix("f1_b2_old_in", 15, 10, FG);
    pix("f1_b2_old_out", 16, 10, 12'h000);
    pix("f1_b3_sat", 19, 14, FG);
    pix("f1_hblank", 20, 14, 12'h000);

    // Frame 2: new value for register 2, frame period
    for (int i = 0; i < 2000 && FrameStart !== 1'b1; i++) @(negedge CLK);
    chk("fs_pos", 32'({PosX, PosY, FrameStart}), 32'd1);
    t0 = cyc;
    @(negedge CLK);
    chk("fs_pulse", 32'(FrameStart), 32'd0);
    pix("f2_b2_new_in", 3, 10, FG);
    pix("f2_b2_new_out", 4, 10, 12'h000);
    for (int i = 0; i < 2000 && FrameStart !== 1'b1; i++) @(negedge CLK);
    chk("fs_period", 32'(cyc - t0), 32'(FRAME_CLK));

    // T6: reset in the middle of a fetch
    for (int i = 0; i < 2000 && !(MemRd === 1'b1 && MemAddrOut === 2'd2); i++) @(negedge CLK);
    chk("t6_at_addr2", 32'({MemRd, MemAddrOut}), 32'd6);
    RESET = 1'b0;
    @(negedge CLK);
    chk("t6_rd_in_rst", 32'(MemRd), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    pix("t6_b0_clear", 2, 1, 12'h000);
    pix("t6_b2_clear", 2, 10, 12'h000);
    pix("t6_b0_back", 5, 1, FG);
    pix("t6_b0_back_out", 6, 1, 12'h000);
    pix("t6_b2_back", 3, 10, FG);
    pix("t6_b2_back_out", 4, 10, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
